// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked scheduler sharing one Uart8 transmitter among NUM_REQ byte streams.
// Grant holds until the reqLast byte completes; a stall watchdog frees a requester that goes quiet mid-packet.
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int GAP_CYCLES  = 0,
    parameter int STALL_LIMIT = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   reqValid,
    input  logic [8*NUM_REQ-1:0] reqData,
    input  logic [NUM_REQ-1:0]   reqLast,
    output logic [NUM_REQ-1:0]   reqReady,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 abort,
    output logic                 busy,
    output logic                 txEn,
    output logic                 txStart,
    output logic [7:0]           txData,
    input  logic                 txBusy,
    input  logic                 txDone,
    output logic [3:0]           dbgState
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SW = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        GAP   = 3'd4
    } stateT;

    stateT          state, stateNext;
    logic [NUM_REQ-1:0] grantNext;
    logic [PW-1:0]  gIdx, gIdxNext;
    logic [PW-1:0]  ptr, ptrNext;
    logic [7:0]     txDataNext;
    logic           lastFlag, lastNext;
    logic [SW-1:0]  stallCnt, stallNext;
    logic [GW-1:0]  gapCnt, gapNext;
    logic           abortNext;
    logic           doExit;

    logic [PW-1:0]  winIdx;
    logic [PW:0]    cand;
    logic           found;

    // Upward search from ptr+1 with wrap-around; cand is one bit wider so the wrap compare cannot overflow.
    always_comb begin
        winIdx = ptr;
        found  = 1'b0;
        cand   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, ptr} + (PW+1)'(k);
            if (cand >= (PW+1)'(NUM_REQ)) cand = cand - (PW+1)'(NUM_REQ);
            if (!found && reqValid[cand[PW-1:0]]) begin
                found  = 1'b1;
                winIdx = cand[PW-1:0];
            end
        end
    end

    logic       validG;
    logic       lastG;
    logic [7:0] dataG;
    assign validG = reqValid[gIdx];
    assign lastG  = reqLast[gIdx];
    assign dataG  = reqData[{gIdx, 3'b000} +: 8];

    always_comb begin
        stateNext  = state;
        grantNext  = grant;
        gIdxNext   = gIdx;
        ptrNext    = ptr;
        txDataNext = txData;
        lastNext   = lastFlag;
        stallNext  = stallCnt;
        gapNext    = gapCnt;
        abortNext  = 1'b0;
        doExit     = 1'b0;
        case (state)
            IDLE: begin
                if (|reqValid) begin
                    grantNext         = '0;
                    grantNext[winIdx] = 1'b1;
                    gIdxNext          = winIdx;
                    stallNext         = '0;
                    stateNext         = LOAD;
                end
            end
            LOAD: begin
                if (validG) begin
                    txDataNext = dataG;
                    lastNext   = lastG;
                    stallNext  = '0;
                    stateNext  = START;
                end else if (stallCnt == SW'(STALL_LIMIT - 1)) begin
                    abortNext = 1'b1;
                    grantNext = '0;
                    ptrNext   = gIdx;
                    stateNext = IDLE;
                end else begin
                    stallNext = stallCnt + 1'b1;
                end
            end
            START: stateNext = WAIT;
            WAIT: begin
                if (txDone) begin
                    if (GAP_CYCLES > 0) begin
                        gapNext   = '0;
                        stateNext = GAP;
                    end else begin
                        doExit = 1'b1;
                    end
                end
            end
            GAP: begin
                if (gapCnt == GW'(GAP_CYCLES - 1)) doExit = 1'b1;
                else                               gapNext = gapCnt + 1'b1;
            end
            default: stateNext = IDLE;
        endcase
        // Shared exit of the inter-byte gap: release on the last byte, otherwise fetch the next one.
        if (doExit) begin
            stallNext = '0;
            if (lastFlag) begin
                grantNext = '0;
                ptrNext   = gIdx;
                stateNext = IDLE;
            end else begin
                stateNext = LOAD;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            grant    <= '0;
            gIdx     <= '0;
            ptr      <= PW'(NUM_REQ - 1);
            txData   <= '0;
            lastFlag <= 1'b0;
            stallCnt <= '0;
            gapCnt   <= '0;
            abort    <= 1'b0;
            txEn     <= 1'b0;
        end else begin
            state    <= stateNext;
            grant    <= grantNext;
            gIdx     <= gIdxNext;
            ptr      <= ptrNext;
            txData   <= txDataNext;
            lastFlag <= lastNext;
            stallCnt <= stallNext;
            gapCnt   <= gapNext;
            abort    <= abortNext;
            txEn     <= 1'b1;
        end
    end

    assign reqReady = (state == LOAD) ? grant : '0;
    assign txStart  = (state == START);
    assign busy     = (state != IDLE);
    // Upper bit mirrors the UART busy monitor; sequencing itself only follows txDone.
    assign dbgState = {txBusy, state};

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a scoreboard of expected {grant, txData} per txStart,
// plus directed checks on latency, packet lock, round-robin order, stall abort, gap and reset.
module tb_uart_tx_arbiter;

    localparam int N = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // Instance A: no gap, short watchdog.
    logic [N-1:0]   reqValidA, reqLastA, reqReadyA, grantA;
    logic [8*N-1:0] reqDataA;
    logic           abortA, busyA, txEnA, txStartA, txBusyA, txDoneA;
    logic [7:0]     txDataA;
    logic [3:0]     dbgStateA;
    logic [2:0]     cntA;

    // Instance B: five-clock gap.
    logic [N-1:0]   reqValidB, reqLastB, reqReadyB, grantB;
    logic [8*N-1:0] reqDataB;
    logic           abortB, busyB, txEnB, txStartB, txBusyB, txDoneB;
    logic [7:0]     txDataB;
    logic [3:0]     dbgStateB;
    logic [2:0]     cntB;

    uart_tx_arbiter #(.NUM_REQ(N), .GAP_CYCLES(0), .STALL_LIMIT(16)) dutA (
        .clk(clk), .reset(reset), .reqValid(reqValidA), .reqData(reqDataA), .reqLast(reqLastA),
        .reqReady(reqReadyA), .grant(grantA), .abort(abortA), .busy(busyA), .txEn(txEnA),
        .txStart(txStartA), .txData(txDataA), .txBusy(txBusyA), .txDone(txDoneA), .dbgState(dbgStateA)
    );

    uart_tx_arbiter #(.NUM_REQ(N), .GAP_CYCLES(5), .STALL_LIMIT(16)) dutB (
        .clk(clk), .reset(reset), .reqValid(reqValidB), .reqData(reqDataB), .reqLast(reqLastB),
        .reqReady(reqReadyB), .grant(grantB), .abort(abortB), .busy(busyB), .txEn(txEnB),
        .txStart(txStartB), .txData(txDataB), .txBusy(txBusyB), .txDone(txDoneB), .dbgState(dbgStateB)
    );

    // Minimal Uart8 stand-ins: txDone pulses a few clocks after each txStart.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            txBusyA <= 1'b0; txDoneA <= 1'b0; cntA <= '0;
        end else begin
            txDoneA <= 1'b0;
            if (txStartA) begin
                txBusyA <= 1'b1; cntA <= 3'd3;
            end else if (txBusyA) begin
                if (cntA == 3'd1) begin txBusyA <= 1'b0; txDoneA <= 1'b1; end
                cntA <= cntA - 3'd1;
            end
        end
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            txBusyB <= 1'b0; txDoneB <= 1'b0; cntB <= '0;
        end else begin
            txDoneB <= 1'b0;
            if (txStartB) begin
                txBusyB <= 1'b1; cntB <= 3'd3;
            end else if (txBusyB) begin
                if (cntB == 3'd1) begin txBusyB <= 1'b0; txDoneB <= 1'b1; end
                cntB <= cntB - 3'd1;
            end
        end
    end

    int checks = 0;
    int failures = 0;
    int abortCntA = 0;
    logic [11:0] exp_qa[$];
    logic [11:0] exp_qb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every txStart must match the next expected {grant, txData}.
    always @(negedge clk) begin
        logic [11:0] e;
        if (reset && abortA) abortCntA++;
        if (reset && txStartA) begin
            if (exp_qa.size() == 0) begin
                checks++; failures++;
                $display("FAIL sb_a unexpected start actual=%0h expected=none", {grantA, txDataA});
            end else begin
                e = exp_qa.pop_front();
                check("sb_a", {20'd0, grantA, txDataA}, {20'd0, e});
            end
        end
        if (reset && txStartB) begin
            if (exp_qb.size() == 0) begin
                checks++; failures++;
                $display("FAIL sb_b unexpected start actual=%0h expected=none", {grantB, txDataB});
            end else begin
                e = exp_qb.pop_front();
                check("sb_b", {20'd0, grantB, txDataB}, {20'd0, e});
            end
        end
    end

    task automatic sendByte(input int sel, input int r, input logic [7:0] d, input logic last);
        logic got;
        got = 1'b0;
        if (sel == 0) begin
            reqDataA[r*8 +: 8] = d; reqLastA[r] = last; reqValidA[r] = 1'b1;
        end else begin
            reqDataB[r*8 +: 8] = d; reqLastB[r] = last; reqValidB[r] = 1'b1;
        end
        for (int c = 0; c < 300 && !got; c++) begin
            @(negedge clk);
            got = (sel == 0) ? reqReadyA[r] : reqReadyB[r];
        end
        check("send_ready", {31'd0, got}, 32'd1);
        @(posedge clk);
        #1;
        if (sel == 0) begin reqValidA[r] = 1'b0; reqLastA[r] = 1'b0; end
        else          begin reqValidB[r] = 1'b0; reqLastB[r] = 1'b0; end
    endtask

    task automatic waitIdle(input int sel);
        logic idle;
        idle = 1'b0;
        for (int c = 0; c < 300 && !idle; c++) begin
            @(negedge clk);
            idle = (sel == 0) ? !busyA : !busyB;
        end
        check("idle_reached", {31'd0, idle}, 32'd1);
    endtask

    task automatic rrSource(input int r);
        for (int k = 0; k < 2; k++) sendByte(0, r, 8'(16*r + k), 1'b1);
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int loads;
        int gapClks;
        logic seen;
        reqValidA = '0; reqLastA = '0; reqDataA = '0;
        reqValidB = '0; reqLastB = '0; reqDataB = '0;

        // Reset values while reset is held.
        #12;
        check("rst_grant", {28'd0, grantA}, 32'd0);
        check("rst_ready", {28'd0, reqReadyA}, 32'd0);
        check("rst_busy", {31'd0, busyA}, 32'd0);
        check("rst_txen", {31'd0, txEnA}, 32'd0);
        check("rst_txstart", {31'd0, txStartA}, 32'd0);
        check("rst_txdata", {24'd0, txDataA}, 32'd0);
        check("rst_abort", {31'd0, abortA}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("txen_after_reset", {31'd0, txEnA}, 32'd1);

        // Single byte: latency from reqValid to reqReady to txStart.
        exp_qa.push_back({4'b0001, 8'h55});
        reqDataA[7:0] = 8'h55; reqLastA[0] = 1'b1; reqValidA[0] = 1'b1;
        @(negedge clk);
        check("single_grant", {28'd0, grantA}, 32'h1);
        check("single_ready", {28'd0, reqReadyA}, 32'h1);
        @(posedge clk);
        #1;
        reqValidA[0] = 1'b0; reqLastA[0] = 1'b0;
        @(negedge clk);
        check("single_txstart", {31'd0, txStartA}, 32'd1);
        check("single_txdata", {24'd0, txDataA}, 32'h55);
        waitIdle(0);
        check("single_release", {28'd0, grantA}, 32'd0);

        // Packet lock: requester 1 owns the line for three bytes while requester 2 waits.
        exp_qa.push_back({4'b0010, 8'hA1});
        exp_qa.push_back({4'b0010, 8'hA2});
        exp_qa.push_back({4'b0010, 8'hA3});
        exp_qa.push_back({4'b0100, 8'hB1});
        fork
            begin
                sendByte(0, 1, 8'hA1, 1'b0);
                sendByte(0, 1, 8'hA2, 1'b0);
                sendByte(0, 1, 8'hA3, 1'b1);
            end
            sendByte(0, 2, 8'hB1, 1'b1);
        join
        waitIdle(0);

        // Round-robin from a fresh reset: 0,1,2,3,0,1,2,3.
        doReset();
        for (int k = 0; k < 2; k++)
            for (int r = 0; r < N; r++) exp_qa.push_back({4'(1 << r), 8'(16*r + k)});
        fork
            rrSource(0);
            rrSource(1);
            rrSource(2);
            rrSource(3);
        join
        waitIdle(0);

        // Stall: requester 3 sends a non-last byte then goes quiet.
        exp_qa.push_back({4'b1000, 8'h3C});
        exp_qa.push_back({4'b0001, 8'h0A});
        abortCntA = 0;
        sendByte(0, 3, 8'h3C, 1'b0);
        loads = 0;
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            if (abortA) seen = 1'b1;
            else if (reqReadyA[3]) loads++;
        end
        check("stall_abort_seen", {31'd0, seen}, 32'd1);
        check("stall_load_clocks", loads, 32'd16);
        check("stall_grant_cleared", {28'd0, grantA}, 32'd0);
        check("stall_busy", {31'd0, busyA}, 32'd0);
        sendByte(0, 0, 8'h0A, 1'b1);
        waitIdle(0);
        check("stall_abort_once", abortCntA, 32'd1);

        // Reset while a byte is in WAIT.
        exp_qa.push_back({4'b0010, 8'h77});
        sendByte(0, 1, 8'h77, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check("mid_state_wait", {29'd0, dbgStateA[2:0]}, 32'd3);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_grant", {28'd0, grantA}, 32'd0);
        check("mid_rst_ready", {28'd0, reqReadyA}, 32'd0);
        check("mid_rst_busy", {31'd0, busyA}, 32'd0);
        check("mid_rst_txen", {31'd0, txEnA}, 32'd0);
        check("mid_rst_txstart", {31'd0, txStartA}, 32'd0);
        check("mid_rst_txdata", {24'd0, txDataA}, 32'd0);
        check("mid_rst_abort", {31'd0, abortA}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        exp_qa.push_back({4'b0001, 8'hE0});
        exp_qa.push_back({4'b0100, 8'hE2});
        fork
            sendByte(0, 0, 8'hE0, 1'b1);
            sendByte(0, 2, 8'hE2, 1'b1);
        join
        waitIdle(0);

        // Gap: five idle clocks between txDone and the next reqReady.
        exp_qb.push_back({4'b0010, 8'hC1});
        exp_qb.push_back({4'b0010, 8'hC2});
        fork
            begin
                sendByte(1, 1, 8'hC1, 1'b0);
                sendByte(1, 1, 8'hC2, 1'b1);
            end
            begin
                seen = 1'b0;
                for (int c = 0; c < 200 && !seen; c++) begin
                    @(negedge clk);
                    seen = txDoneB;
                end
                check("gap_done_seen", {31'd0, seen}, 32'd1);
                gapClks = 0;
                seen = 1'b0;
                for (int c = 0; c < 50 && !seen; c++) begin
                    @(negedge clk);
                    if (reqReadyB[1]) seen = 1'b1;
                    else gapClks++;
                end
                check("gap_clocks", gapClks, 32'd5);
            end
        join
        waitIdle(1);
        check("gap_release", {28'd0, grantB}, 32'd0);

        @(negedge clk);
        check("sb_a_drained", exp_qa.size(), 32'd0);
        check("sb_b_drained", exp_qb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares the transmitter of one `Uart8` instance among `NUM_REQ` byte-stream requesters. Grant is held per packet: a requester keeps the transmitter until its byte flagged `reqLast` has finished on the line. The block sits between the requesters and the `Uart8` tx interface: it drives `txEn`, `txStart` and `txData`, and consumes `txBusy` and `txDone`. A stall watchdog releases a requester that stops supplying bytes mid-packet.

## Interface
- `NUM_REQ`, default 4: number of requesters, legal range 2..8.
- `GAP_CYCLES`, default 0: idle clocks inserted after each `txDone` before the next load.
- `STALL_LIMIT`, default 1024: consecutive LOAD clocks with the granted `reqValid` low before abort. Minimum 1.
- `clk`  in  1  single system clock.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `reqValid`  in  NUM_REQ  per-requester byte-valid.
- `reqData`  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- `reqLast`  in  NUM_REQ  marks the final byte of a packet; qualified by the transfer.
- `reqReady`  out  NUM_REQ  per-requester accept. A byte transfers on a clock edge where `reqValid[i]` and `reqReady[i]` are both high.
- `grant`  out  NUM_REQ  one-hot current owner; all zero when unowned.
- `abort`  out  1  one-clock pulse when the stall watchdog releases a grant.
- `busy`  out  1  high whenever the state is not IDLE.
- `txEn`  out  1  enable to `Uart8` tx.
- `txStart`  out  1  one-clock start pulse to `Uart8`.
- `txData`  out  8  byte to `Uart8`.
- `txBusy`  in  1  `Uart8` transmitter busy.
- `txDone`  in  1  `Uart8` one-clock completion pulse.

## Operation
- **States:** IDLE, LOAD, START, WAIT, GAP.
- **IDLE:**
  - On an edge with any `reqValid` high, register `grant` to the winner and go to LOAD.
  - Winner is the first set bit searching upward, with wrap-around, from `ptr+1`.
  - `ptr` is the last released index and resets to `NUM_REQ-1`, so requester 0 wins first after reset.
- **LOAD:**
  - `reqReady[g]` is high, combinationally, iff `grant[g]`. All other `reqReady` bits are 0.
  - On transfer: capture `txData <= reqData[g]` and `lastFlag <= reqLast[g]`, clear the stall counter, and go to START.
- **START:** `txStart` = 1 for exactly one clock; then go to WAIT.
- **WAIT:**
  - Hold `txData` stable.
  - On `txDone`: if `GAP_CYCLES > 0` go to GAP; otherwise go to the GAP exit target directly.
- **GAP:**
  - Count `GAP_CYCLES` clocks.
  - Exit: if `lastFlag`, release the grant (`grant <= 0`, `ptr <= g`) and go to IDLE; else go to LOAD with the grant unchanged.
- **Stall watchdog:**
  - In LOAD, the counter increments on each clock with `reqValid[g]` low.
  - When the count reaches `STALL_LIMIT`: pulse `abort`, set `grant <= 0` and `ptr <= g`, and go to IDLE.
  - The counter clears on every entry to LOAD.
- `txEn` is 1 at all times outside reset.
- `txBusy` is not used for sequencing; it is a monitor input only. Sequencing follows `txDone`.
- Requests from other requesters while a grant is held are ignored until release. Fairness comes from advancing `ptr`.

## Timing
- **Reset values:** state IDLE; `grant` = 0; `reqReady` = 0; `txStart` = 0; `txData` = 0; `abort` = 0; `busy` = 0; `txEn` = 0 during reset; `ptr` = `NUM_REQ-1`.
- **Mid-operation reset:** all of the above apply immediately, whatever the current state. An in-flight byte is abandoned; the `Uart8` instance shares the same reset.
- **Latency, request to start:** `reqValid` sampled in IDLE at edge N → `reqReady` high during clock N+1 → transfer at edge N+1 → `txStart` high during clock N+2.
- **Back-to-back bytes** (`GAP_CYCLES`=0): `reqReady` is high on the clock after `txDone`.
- **`txDone` in the same clock as a new `reqValid` from another requester:** no effect. Arbitration happens only in IDLE, one clock after release at the earliest.
- **`reqLast` on a single-byte packet:** grant is released after that byte's `txDone`.
- **Abort:** the `abort` pulse occurs on the clock after the counter reaches `STALL_LIMIT`. Arbitration for the next owner happens in the IDLE clock that follows.

## Test plan
- **Single byte:** requester 0 sends 8'h55 with `reqLast`=1.
  - `grant`=4'b0001; one `txStart` with `txData`=8'h55.
  - After `txDone`: `grant`=0 and `busy`=0.
- **Packet lock:** requester 1 sends 3 bytes (8'hA1, 8'hA2, 8'hA3 with last) while requester 2 holds `reqValid` high throughout.
  - All three bytes go out in order before `grant`=4'b0100.
- **Round-robin:** all four `reqValid` held high with single-byte packets.
  - Grant order is 0,1,2,3,0; no requester is granted twice in a row.
- **Stall:** requester 3 sends one non-last byte, then drops `reqValid` (`STALL_LIMIT`=16).
  - `abort` pulses once after 16 LOAD clocks; `grant`=0; then requester 0 is granted if valid.
- **Gap:** `GAP_CYCLES`=5 with two bytes.
  - Exactly 5 clocks between `txDone` and the next `reqReady`.
- **Reset in WAIT:** assert `reset`=0 mid-byte.
  - All outputs return to reset values asynchronously; after release, requester 0 wins first.
